// File: rtl/uart_wb_bridge_pkg.sv
// Shared constants and state types for the UART-to-Wishbone debug bridge.
package uart_wb_bridge_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_RESP,
    ST_SEND
  } state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_wb_bridge_if.sv
// Classic WB4 single-cycle bus bundle; dat_o flows master->slave, dat_i slave->master.
interface uart_wb_bridge_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic [3:0]  sel;
  logic        ack;
  logic        err;

  modport master (output cyc, stb, we, adr, dat_o, sel, input dat_i, ack, err);
  modport slave  (input cyc, stb, we, adr, dat_o, sel, output dat_i, ack, err);
endinterface

// File: rtl/uart_wb_bridge_uart_phy.sv
// 8N1 UART deserializer (2-flop synchronized, centre sampled) and serializer
// with a tx_valid/tx_ready handshake. Requires CLK_HZ/BAUD >= 2.
module uart_phy
  import uart_wb_bridge_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_ferr,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready
);

  localparam int unsigned DIV  = CLK_HZ / BAUD;
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned CW   = $clog2(DIV + 1);

  rx_state_e       rx_st_q, rx_st_d;
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_sh_q, rx_sh_d;
  logic            rx_valid_q, rx_valid_d, rx_ferr_q, rx_ferr_d;

  logic            tx_act_q, tx_act_d;
  logic [8:0]      tx_sh_q, tx_sh_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [3:0]      tx_bit_q, tx_bit_d;
  logic            tx_line_q, tx_line_d;
  logic            tx_last;

  always_comb begin
    rx_st_d    = rx_st_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    unique case (rx_st_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_st_d = RX_START;
      end
      RX_START: if (rx_cnt_q == CW'(HALF - 1)) begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        rx_st_d  = rx_sync_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == CW'(DIV - 1)) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 1'b1;
        if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
      end
      RX_STOP: if (rx_cnt_q == CW'(DIV - 1)) begin
        rx_cnt_d   = '0;
        rx_st_d    = RX_IDLE;
        rx_valid_d = rx_sync_q;
        rx_ferr_d  = !rx_sync_q;
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  // The stop bit is held DIV-1 cycles while active; the final cycle is spent
  // idle with tx_ready high so a queued byte starts with no gap.
  assign tx_last = (tx_bit_q == 4'd9) ? (tx_cnt_q == CW'(DIV - 2))
                                      : (tx_cnt_q == CW'(DIV - 1));

  always_comb begin
    tx_act_d  = tx_act_q;
    tx_sh_d   = tx_sh_q;
    tx_cnt_d  = tx_cnt_q;
    tx_bit_d  = tx_bit_q;
    tx_line_d = tx_line_q;
    if (!tx_act_q) begin
      tx_line_d = 1'b1;
      if (tx_valid) begin
        tx_act_d  = 1'b1;
        tx_sh_d   = {1'b1, tx_data};
        tx_cnt_d  = '0;
        tx_bit_d  = '0;
        tx_line_d = 1'b0;
      end
    end else if (tx_last) begin
      tx_cnt_d = '0;
      if (tx_bit_q == 4'd9) begin
        tx_act_d  = 1'b0;
        tx_line_d = 1'b1;
      end else begin
        tx_bit_d  = tx_bit_q + 1'b1;
        tx_line_d = tx_sh_q[0];
        tx_sh_d   = {1'b1, tx_sh_q[8:1]};
      end
    end else begin
      tx_cnt_d = tx_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_st_q    <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      tx_act_q   <= 1'b0;
      tx_sh_q    <= '0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_line_q  <= 1'b1;
    end else begin
      rx_meta_q  <= uart_rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_st_q    <= rx_st_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
      tx_act_q   <= tx_act_d;
      tx_sh_q    <= tx_sh_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_line_q  <= tx_line_d;
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_sh_q;
  assign rx_ferr  = rx_ferr_q;
  assign tx_ready = !tx_act_q;
  assign uart_tx  = tx_line_q;

endmodule

// File: rtl/uart_wb_bridge.sv
// UART-driven Wishbone master: parses W/R command frames, runs one classic
// WB4 cycle, and answers with K (+ read data) or E.
module uart_wb_bridge
  import uart_wb_bridge_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned WB_TIMEOUT   = 255,
  parameter int unsigned BYTE_TIMEOUT = 5_000_000
) (
  input  logic                clk,
  input  logic                rst,
  uart_wb_bridge_if.master    wb,
  input  logic                uart_rx,
  output logic                uart_tx,
  output logic                busy
);

  localparam int unsigned WT_W = $clog2(WB_TIMEOUT + 1) + 1;
  localparam int unsigned BT_W = $clog2(BYTE_TIMEOUT + 1) + 1;

  logic       rx_valid, rx_ferr, tx_valid, tx_ready;
  logic [7:0] rx_data, tx_data;

  state_e          st_q, st_d;
  logic            we_q, we_d, fail_q, fail_d, cyc_q, cyc_d, busy_q, busy_d;
  logic [31:0]     adr_q, adr_d, dat_q, dat_d, rdat_q, rdat_d;
  logic [2:0]      idx_q, idx_d, nbytes;
  logic [WT_W-1:0] wt_q, wt_d;
  logic [BT_W-1:0] bt_q, bt_d;

  uart_phy #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_phy (
    .clk      (clk),
    .rst      (rst),
    .uart_rx  (uart_rx),
    .uart_tx  (uart_tx),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ferr  (rx_ferr),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
  );

  assign nbytes = (fail_q || we_q) ? 3'd1 : 3'd5;

  always_comb begin
    st_d     = st_q;
    we_d     = we_q;
    fail_d   = fail_q;
    cyc_d    = cyc_q;
    busy_d   = busy_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    rdat_d   = rdat_q;
    idx_d    = idx_q;
    wt_d     = '0;
    bt_d     = '0;
    tx_valid = 1'b0;
    tx_data  = fail_q ? RSP_ERR : RSP_OK;
    unique case (st_q)
      ST_IDLE: if (rx_valid && (rx_data == CMD_WR || rx_data == CMD_RD)) begin
        we_d   = (rx_data == CMD_WR);
        fail_d = 1'b0;
        idx_d  = '0;
        busy_d = 1'b1;
        st_d   = ST_ADDR;
      end
      ST_ADDR, ST_DATA: begin
        bt_d = bt_q + 1'b1;
        if (rx_ferr) begin
          busy_d = 1'b0;
          st_d   = ST_IDLE;
        end else if (rx_valid) begin
          bt_d  = '0;
          idx_d = idx_q + 1'b1;
          if (st_q == ST_ADDR) adr_d[{idx_q[1:0], 3'b000} +: 8] = rx_data;
          else                 dat_d[{idx_q[1:0], 3'b000} +: 8] = rx_data;
          if (idx_q == 3'd3) begin
            idx_d = '0;
            if (st_q == ST_ADDR && we_q) begin
              st_d = ST_DATA;
            end else begin
              st_d  = ST_BUS;
              cyc_d = 1'b1;
            end
          end
        end else if (bt_q == BT_W'(BYTE_TIMEOUT - 1)) begin
          busy_d = 1'b0;
          st_d   = ST_IDLE;
        end
      end
      // err takes priority over a simultaneous ack
      ST_BUS: begin
        wt_d = wt_q + 1'b1;
        if (wb.err || wt_q == WT_W'(WB_TIMEOUT)) begin
          fail_d = 1'b1;
          cyc_d  = 1'b0;
          st_d   = ST_RESP;
        end else if (wb.ack) begin
          rdat_d = wb.dat_i;
          cyc_d  = 1'b0;
          st_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        idx_d = '0;
        st_d  = ST_SEND;
      end
      ST_SEND: begin
        tx_valid = (idx_q < nbytes);
        if (idx_q != 3'd0) tx_data = rdat_q[{idx_q[1:0] - 2'd1, 3'b000} +: 8];
        if (tx_valid && tx_ready) begin
          idx_d = idx_q + 1'b1;
        end else if (!tx_valid && tx_ready) begin
          busy_d = 1'b0;
          st_d   = ST_IDLE;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= ST_IDLE;
      we_q   <= 1'b0;
      fail_q <= 1'b0;
      cyc_q  <= 1'b0;
      busy_q <= 1'b0;
      adr_q  <= '0;
      dat_q  <= '0;
      rdat_q <= '0;
      idx_q  <= '0;
      wt_q   <= '0;
      bt_q   <= '0;
    end else begin
      st_q   <= st_d;
      we_q   <= we_d;
      fail_q <= fail_d;
      cyc_q  <= cyc_d;
      busy_q <= busy_d;
      adr_q  <= adr_d;
      dat_q  <= dat_d;
      rdat_q <= rdat_d;
      idx_q  <= idx_d;
      wt_q   <= wt_d;
      bt_q   <= bt_d;
    end
  end

  assign wb.cyc   = cyc_q;
  assign wb.stb   = cyc_q;
  assign wb.we    = we_q & cyc_q;
  assign wb.sel   = cyc_q ? 4'hF : 4'h0;
  assign wb.adr   = adr_q;
  assign wb.dat_o = dat_q;
  assign busy     = busy_q;

endmodule

// File: doc/uart_wb_bridge.md
# uart_wb_bridge

UART-driven Wishbone master for host-side debug and program loading. It receives framed read/write commands on a UART RX line, runs single classic WB4 cycles on a master port, and returns status and read data on a UART TX line. In the SoC it is a second initiator next to the CPU data bus, muxed through the existing arbitration, so a PC can read and write RAM and peripherals while the core is running or held.

## Interface
Parameters:
- CLK_HZ, 50_000_000: clk frequency in Hz.
- BAUD, 115200: UART bit rate. Divisor is CLK_HZ/BAUD, integer-truncated.
- WB_TIMEOUT, 255: maximum clk cycles to wait for ack/err.
- BYTE_TIMEOUT, 5_000_000: maximum idle clk cycles between bytes of one command.

Ports:
- clk, input, 1: single clock for the whole block.
- rst, input, 1: reset, asynchronous, active-high.
- wb, WB4 master, –: uses cyc, stb, we, adr[31:0], dat_o[31:0], dat_i[31:0], sel[3:0], ack, err.
- uart_rx, input, 1: serial in, 8N1, idle high.
- uart_tx, output, 1: serial out, 8N1, idle high.
- busy, output, 1: high from first command byte accepted until last response stop bit sent.

## Operation
- Command frame:
  - write: 0x57 ('W'), A0..A3, D0..D3.
  - read: 0x52 ('R'), A0..A3.
  - A and D are little-endian (A0 = adr[7:0]).
- Response:
  - write OK: 0x4B ('K').
  - read OK: 0x4B, then D0..D3 little-endian from dat_i latched on ack.
  - any failure: 0x45 ('E') only.
- WB cycle: sel=4'hF, adr as received (no alignment check), we=1 for write. cyc and stb rise together and are held until ack, err or timeout.
- States: IDLE → ADDR (4 bytes) → DATA (4 bytes, write only) → BUS → RESP → SEND → IDLE.
  - IDLE: any byte other than 0x57/0x52 is discarded. No response, stay in IDLE.
  - ADDR/DATA: a 3-bit byte index counts received bytes.
  - BUS: on ack, latch dat_i and go to RESP. On err, or when the wait counter reaches WB_TIMEOUT, go to RESP with failure flag.
  - RESP/SEND: queue 1 or 5 bytes to the TX serializer, sequenced by byte index.
- Half-duplex: bytes received while in BUS, RESP or SEND are discarded.
- Inter-byte timeout: in ADDR/DATA, BYTE_TIMEOUT cycles without a new byte → IDLE silently, partial command dropped.
- Framing error (stop bit sampled low): byte discarded. If in ADDR/DATA, return to IDLE.
- RX path: 2-flop synchronizer. Start detected on falling edge, re-checked at half-bit, then data sampled at bit centres, LSB first.

## Timing
- Reset values: uart_tx=1, busy=0, cyc=stb=we=0, adr=0, dat_o=0, sel=0. All internal counters 0, state IDLE.
- rst asserted mid-operation:
  - WB cycle aborted, cyc/stb low asynchronously.
  - TX frame truncated, line forced high.
  - No response emitted after release.
- cyc/stb assert on the clk edge after the stop-bit sample of the last command byte.
- cyc/stb deassert on the clk edge after ack or err is sampled high. ack and err in the same cycle are treated as err.
- Timeout: cyc/stb deassert on the edge where the wait counter equals WB_TIMEOUT, i.e. WB_TIMEOUT+1 cycles after assertion. Failure is reported.
- Response start bit begins at most 2 clk after cyc/stb deassert.
- Consecutive response bytes go back-to-back: start bit immediately follows the previous stop bit.
- Each bit lasts CLK_HZ/BAUD clk cycles.
- busy drops on the clk edge after the final stop bit completes.

## Structure
- Shared package:
  - command byte constants CMD_WR=8'h57, CMD_RD=8'h52.
  - response constants RSP_OK=8'h4B, RSP_ERR=8'h45.
  - state enum for the bridge FSM.
- Sub-module uart_phy (parameters CLK_HZ, BAUD) contains:
  - the RX deserializer, with output pulses rx_valid, rx_data[7:0], rx_ferr.
  - the TX serializer, with tx_valid/tx_ready handshake (tx_ready high only when the shifter is idle).
- uart_wb_bridge holds the command FSM, address/data shift registers, timeout counters and the WB master logic.

## Test plan
- Write: send 57 00 01 00 00 EF BE AD DE.
  - One WB cycle: we=1, adr=0x00000100, dat_o=0xDEADBEEF, sel=F.
  - Slave acks after 3 cycles → TX emits single 0x4B.
- Read: send 52 00 01 00 00, slave returns 0x12345678 → TX emits 4B 78 56 34 12.
- Unknown command: send 0x41, then a valid read.
  - No cycle and no response for 0x41.
  - Read completes normally.
- Slave never acks (WB_TIMEOUT=16) on read → cyc high exactly 17 cycles → TX 0x45 only.
- Slave asserts err on write → cyc drops the next edge → TX 0x45.
- Partial command: send 52 00 01, then idle > BYTE_TIMEOUT.
  - No WB cycle, busy returns low.
  - A full command sent afterwards executes correctly.
